ospi_host_ctrl: RTL

- Octal-SPI host (initiator) sequencer that drives the FPGA OSPI target's bus. Sits directly upstream of the target.
- Accepts one transfer request at a time (command, length, 24-bit address) on a valid/ready interface.
- Serialises the request into the 5-byte SDR command header; streams write bytes out, or read bytes back on a stream.
- Generates chip-select and the per-cycle clock-enable that the top level forwards as the bus clock via ODDR.

---
 rtl/ospi_pkg.sv | 20 ++
 rtl/ospi_hdr_ser.sv | 34 +++
 rtl/ospi_host_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ospi_pkg.sv
// Shared constants and state type for the octal-SPI host and target.
package ospi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'hA0;
  localparam logic [7:0] CMD_READ  = 8'h20;
  localparam int         HDR_LEN   = 5;
  localparam int         DUMMY_CYC = 2;
  localparam int         CS_GAP    = 2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DUMMY,
    WDATA,
    RDATA,
    TAIL,
    GAP
  } state_t;

endpackage

// File: rtl/ospi_hdr_ser.sv
// Command header serialiser: the opcode goes out on load, the four remaining
// header bytes follow one per advance, with last flagging the final byte.
module ospi_hdr_ser
  import ospi_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        advance,
  input  logic [39:0] hdr,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0] sr;
  logic [2:0]  idx;

  assign byte_out = load ? hdr[39:32] : sr[31:24];
  assign last     = (idx == 3'(HDR_LEN - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= hdr[31:0];
      idx <= 3'd1;
    end else if (advance) begin
      sr  <= {sr[23:0], 8'h00};
      idx <= idx + 3'd1;
    end
  end

endmodule

// File: rtl/ospi_host_ctrl.sv
// Octal-SPI host sequencer: header, dummy, data and tail beats on a gated bus
// clock. The state names the phase whose beat is being loaded into the output flops.
module ospi_host_ctrl #(
  parameter logic [7:0] CMD_WRITE = ospi_pkg::CMD_WRITE,
  parameter logic [7:0] CMD_READ  = ospi_pkg::CMD_READ,
  parameter int         DUMMY_CYC = ospi_pkg::DUMMY_CYC,
  parameter int         CS_GAP    = ospi_pkg::CS_GAP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_len,
  input  logic [23:0] req_addr,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        ospi_ncs,
  output logic        ospi_sck_en,
  output logic [7:0]  ospi_dq_o,
  output logic        ospi_dq_oe,
  input  logic [7:0]  ospi_dq_i
);
  import ospi_pkg::*;

  state_t     state, state_n;
  logic [8:0] rem, rem_n;
  logic [3:0] cnt, cnt_n;
  logic       is_write, is_write_n;
  logic       ncs_n, sck_n, oe_n, done_n;
  logic [7:0] dq_n;
  logic       rd_beat, rd_beat_n;
  logic       hdr_load, hdr_adv, hdr_last;
  logic [7:0] hdr_byte;
  logic [7:0] cap_data;
  logic       cap_vld;

  assign req_ready = (state == IDLE);
  assign wr_ready  = (state == WDATA) && wr_valid;

  ospi_hdr_ser u_hdr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (hdr_load),
    .advance  (hdr_adv),
    .hdr      ({(req_write ? CMD_WRITE : CMD_READ), req_len, req_addr}),
    .byte_out (hdr_byte),
    .last     (hdr_last)
  );

  always_comb begin
    state_n    = state;
    rem_n      = rem;
    cnt_n      = cnt;
    is_write_n = is_write;
    ncs_n      = 1'b1;
    sck_n      = 1'b0;
    oe_n       = 1'b0;
    dq_n       = ospi_dq_o;
    done_n     = 1'b0;
    rd_beat_n  = 1'b0;
    hdr_load   = 1'b0;
    hdr_adv    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          hdr_load   = 1'b1;
          is_write_n = req_write;
          rem_n      = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
          ncs_n      = 1'b0;
          sck_n      = 1'b1;
          oe_n       = 1'b1;
          dq_n       = hdr_byte;
          state_n    = CMD;
        end
      end
      CMD: begin
        hdr_adv = 1'b1;
        ncs_n   = 1'b0;
        sck_n   = 1'b1;
        oe_n    = 1'b1;
        dq_n    = hdr_byte;
        if (hdr_last) begin
          if (is_write) begin
            state_n = WDATA;
          end else begin
            state_n = DUMMY;
            cnt_n   = 4'(DUMMY_CYC);
          end
        end
      end
      DUMMY: begin
        ncs_n = 1'b0;
        sck_n = 1'b1;
        if (cnt == 4'd1) state_n = RDATA;
        else             cnt_n   = cnt - 4'd1;
      end
      // A missing write byte stalls the bus with chip select still asserted.
      WDATA: begin
        ncs_n = 1'b0;
        oe_n  = 1'b1;
        if (wr_valid) begin
          sck_n = 1'b1;
          dq_n  = wr_data;
          rem_n = rem - 9'd1;
          if (rem == 9'd1) state_n = TAIL;
        end
      end
      RDATA: begin
        ncs_n     = 1'b0;
        sck_n     = 1'b1;
        rd_beat_n = 1'b1;
        rem_n     = rem - 9'd1;
        if (rem == 9'd1) state_n = TAIL;
      end
      TAIL: begin
        ncs_n   = 1'b0;
        sck_n   = 1'b1;
        cnt_n   = 4'(CS_GAP);
        state_n = GAP;
      end
      GAP: begin
        done_n = (cnt == 4'(CS_GAP));
        if (cnt == 4'd0) state_n = IDLE;
        else             cnt_n   = cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Read bytes are captured at the edge closing their beat and presented one cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rem         <= '0;
      cnt         <= '0;
      is_write    <= 1'b0;
      ospi_ncs    <= 1'b1;
      ospi_sck_en <= 1'b0;
      ospi_dq_oe  <= 1'b0;
      ospi_dq_o   <= '0;
      done        <= 1'b0;
      rd_beat     <= 1'b0;
      cap_data    <= '0;
      cap_vld     <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      cnt         <= cnt_n;
      is_write    <= is_write_n;
      ospi_ncs    <= ncs_n;
      ospi_sck_en <= sck_n;
      ospi_dq_oe  <= oe_n;
      ospi_dq_o   <= dq_n;
      done        <= done_n;
      rd_beat     <= rd_beat_n;
      cap_vld     <= rd_beat && ospi_sck_en;
      if (rd_beat) cap_data <= ospi_dq_i;
      rd_valid    <= cap_vld;
      rd_data     <= cap_data;
    end
  end

endmodule
